axi_mm_reg_sink: RTL and testbench
==================================

Name: axi_mm_reg_sink

Overview:
- Memory-mapped responder implementing the sink side of the team's AXI-MM style interface (addr, wr_dat, wr, rd, rd_dat, rd_dat_val, wait_rq).
- Holds a bank of read/write control registers and exposes a window of read-only status words.
- Sits between a host-facing AXI-MM source (PCIe/AXI-lite bridge or simulation put_data/get_data tasks) and fabric logic that consumes control words and supplies status.

Parameters:
- D_BITS, 64, data width of wr_dat/rd_dat and of every register.
- A_BITS, 8, address width (word addressing).
- NUM_RW, 4, number of RW registers at addresses 0..NUM_RW-1.
- NUM_RO, 2, number of RO status words at addresses RO_BASE..RO_BASE+NUM_RO-1.
- RO_BASE, 16, first RO address; must be >= NUM_RW and RO_BASE+NUM_RO <= 2^A_BITS.
- RD_LAT, 2, read latency in cycles from accept to rd_dat_val; must be >= 1.

Ports:
- i_clk, input, 1, clock.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_addr, input, A_BITS, word address.
- i_wr_dat, input, D_BITS, write data.
- i_wr, input, 1, write request.
- i_rd, input, 1, read request.
- o_rd_dat, output, D_BITS, read data, valid with o_rd_dat_val.
- o_rd_dat_val, output, 1, single-cycle read-data strobe.
- o_wait_rq, output, 1, registered; source must hold the request while high.
- o_rw_regs, output, NUM_RW*D_BITS, RW register contents; reg k at [k*D_BITS +: D_BITS].
- o_wr_pulse, output, NUM_RW, one-cycle pulse on bit k the cycle after reg k is written.
- i_ro_dat, input, NUM_RO*D_BITS, status words; word j at [j*D_BITS +: D_BITS].

Behaviour:
- Reset (async assert, sync release):
  - o_rd_dat=0, o_rd_dat_val=0, o_wait_rq=0, o_wr_pulse=0.
  - All RW regs=0; read pipeline cleared.
  - A read in flight at reset is dropped; no rd_dat_val is issued after release.
- Accept condition:
  - A request is accepted at a rising edge where (i_wr|i_rd) && !o_wait_rq.
  - Requests seen while o_wait_rq=1 are not accepted and carry no side effects.
- Write:
  - Accepted write to addr k < NUM_RW updates reg k at that edge; o_rw_regs reflects the new value and o_wr_pulse[k]=1 for exactly the next cycle.
  - Writes to RO or unmapped addresses are silently dropped with no pulse.
  - Writes never raise o_wait_rq; back-to-back writes are accepted every cycle.
- Read:
  - Accepted read at edge t samples its data source at t:
    - RW address: register value before any same-edge write.
    - RO address: i_ro_dat word.
    - Unmapped address: 0.
  - The sampled value passes through an RD_LAT-deep pipeline.
  - o_rd_dat_val=1 and o_rd_dat=value in the cycle following edge t+RD_LAT-1, i.e. RD_LAT cycles after accept.
  - o_wait_rq=1 from the cycle after accept up to and including the rd_dat_val cycle, then 0.
  - At most one read is outstanding at a time.
  - o_rd_dat holds its last value when o_rd_dat_val=0.
- Simultaneous wr and rd, same cycle, accepted:
  - Both execute.
  - The read returns the pre-write value (read-before-write).
  - o_wait_rq behaves as for a read.
- State machine:
  - IDLE: o_wait_rq=0; on accepted read go to BUSY and load a latency counter with RD_LAT-1.
  - BUSY: o_wait_rq=1; counter decrements each cycle; when the counter is 0 and rd_dat_val fires, return to IDLE.
  - For RD_LAT=1, BUSY lasts exactly one cycle (the rd_dat_val cycle).
- A new read can be accepted in the first IDLE cycle after rd_dat_val, giving a throughput of one read per RD_LAT+1 cycles.
- Address compare is full-width A_BITS; there is no aliasing.

Test Plan (defaults):
- Reset then read addr 0..3 -> each returns 0; rd_dat_val exactly 2 cycles after accept; wait_rq high for 2 cycles per read.
- put_data 0x1122334455667788 to addr 2 -> o_rw_regs[2]=0x1122334455667788 next cycle; o_wr_pulse=4'b0100 for one cycle; readback equals the written value.
- i_ro_dat word1=0xCAFE; read addr 17 -> 0xCAFE. Write 0xFFFF to addr 17, then read -> still 0xCAFE; no o_wr_pulse.
- Reg1=0xA; one cycle with wr=rd=1, addr 1, wr_dat=0xB -> read returns 0xA; a later read returns 0xB. A write held during wait_rq is accepted only after wait_rq falls.
- Read addr 9 (unmapped) -> rd_dat_val with 0. Read addr 255 -> 0. No pulses, no register changes.
- Accept read, then assert i_rst_n=0 one cycle later -> outputs and registers zero immediately; no rd_dat_val appears after release. Repeat the directed tests with RD_LAT=1 and RD_LAT=5.

Source files
------------

// File: rtl/axi_mm_reg_sink.sv
// AXI-MM sink: bank of RW control registers plus a read-only status window.
// Latency: writes land at the accept edge, read data returns RD_LAT cycles after accept.
// Backpressure: o_wait_rq is high while a read is in flight; writes never stall.
module axi_mm_reg_sink #(
    parameter int D_BITS  = 64,
    parameter int A_BITS  = 8,
    parameter int NUM_RW  = 4,
    parameter int NUM_RO  = 2,
    parameter int RO_BASE = 16,
    parameter int RD_LAT  = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [A_BITS-1:0]        i_addr,
    input  logic [D_BITS-1:0]        i_wr_dat,
    input  logic                     i_wr,
    input  logic                     i_rd,
    output logic [D_BITS-1:0]        o_rd_dat,
    output logic                     o_rd_dat_val,
    output logic                     o_wait_rq,
    output logic [NUM_RW*D_BITS-1:0] o_rw_regs,
    output logic [NUM_RW-1:0]        o_wr_pulse,
    input  logic [NUM_RO*D_BITS-1:0] i_ro_dat
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              wr_acc, rd_acc;
    logic [D_BITS-1:0] rd_sample;
    logic [D_BITS-1:0] rw_q     [NUM_RW];
    logic [D_BITS-1:0] pipe_dat [RD_LAT];
    logic [RD_LAT-1:0] pipe_vld;

    assign o_wait_rq = (state == BUSY);
    assign wr_acc    = i_wr & ~o_wait_rq;
    assign rd_acc    = i_rd & ~o_wait_rq;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The counter reaches zero in exactly the cycle the last pipe stage is valid.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (rd_acc) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CW'(RD_LAT - 1);
                end
            end
            BUSY: begin
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_RW; k++) rw_q[k] <= '0;
            o_wr_pulse <= '0;
        end else begin
            o_wr_pulse <= '0;
            for (int k = 0; k < NUM_RW; k++) begin
                if (wr_acc && (i_addr == A_BITS'(k))) begin
                    rw_q[k]       <= i_wr_dat;
                    o_wr_pulse[k] <= 1'b1;
                end
            end
        end
    end

    // Sampled from register state before this edge's write, giving read-before-write.
    always_comb begin
        rd_sample = '0;
        for (int k = 0; k < NUM_RW; k++)
            if (i_addr == A_BITS'(k)) rd_sample = rw_q[k];
        for (int j = 0; j < NUM_RO; j++)
            if (i_addr == A_BITS'(RO_BASE + j)) rd_sample = i_ro_dat[j*D_BITS +: D_BITS];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_dat[i] <= '0;
        end else begin
            pipe_vld[0] <= rd_acc;
            if (rd_acc) pipe_dat[0] <= rd_sample;
            // Stages only advance on valid so the output holds the last read value.
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    assign o_rd_dat     = pipe_dat[RD_LAT-1];
    assign o_rd_dat_val = pipe_vld[RD_LAT-1];

    for (genvar k = 0; k < NUM_RW; k++) begin : g_rw_out
        assign o_rw_regs[k*D_BITS +: D_BITS] = rw_q[k];
    end

endmodule

// File: tb/tb_axi_mm_reg_sink.sv
// Directed bench for axi_mm_reg_sink, run against three instances with RD_LAT = 2, 1 and 5.
module tb_axi_mm_reg_sink;
    localparam int D   = 64;
    localparam int A   = 8;
    localparam int NRW = 4;
    localparam int NRO = 2;
    localparam int W   = NRW * D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [A-1:0]    addr       [3];
    logic [D-1:0]    wr_dat     [3];
    logic            wr         [3];
    logic            rd         [3];
    logic [D-1:0]    rd_dat     [3];
    logic            rd_dat_val [3];
    logic            wait_rq    [3];
    logic [W-1:0]    rw_regs    [3];
    logic [NRW-1:0]  wr_pulse   [3];
    logic [NRO*D-1:0] ro_dat;

    int n_tests = 0;
    int n_fail  = 0;
    int sel;
    int lat;
    logic [D-1:0] m_rw [NRW];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        axi_mm_reg_sink #(
            .D_BITS(D), .A_BITS(A), .NUM_RW(NRW), .NUM_RO(NRO), .RO_BASE(16),
            .RD_LAT(g == 0 ? 2 : (g == 1 ? 1 : 5))
        ) dut (
            .i_clk        (clk),
            .i_rst_n      (rst_n),
            .i_addr       (addr[g]),
            .i_wr_dat     (wr_dat[g]),
            .i_wr         (wr[g]),
            .i_rd         (rd[g]),
            .o_rd_dat     (rd_dat[g]),
            .o_rd_dat_val (rd_dat_val[g]),
            .o_wait_rq    (wait_rq[g]),
            .o_rw_regs    (rw_regs[g]),
            .o_wr_pulse   (wr_pulse[g]),
            .i_ro_dat     (ro_dat)
        );
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (lat=%0d): observed %0h expected %0h", tag, lat, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] m_pack();
        logic [W-1:0] r;
        for (int k = 0; k < NRW; k++) r[k*D +: D] = m_rw[k];
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < NRW; k++) m_rw[k] = '0;
        addr[sel] = '0; wr[sel] = 1'b0; rd[sel] = 1'b0; wr_dat[sel] = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_regs",  rw_regs[sel], '0);
        chk("rst_pulse", W'(wr_pulse[sel]), '0);
        chk("rst_wait",  W'(wait_rq[sel]), '0);
        chk("rst_val",   W'(rd_dat_val[sel]), '0);
        chk("rst_dat",   W'(rd_dat[sel]), '0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_wr(input logic [A-1:0] a, input logic [D-1:0] d, input string tag);
        logic [NRW-1:0] exp_p;
        exp_p = (a < NRW) ? NRW'(1 << a) : '0;
        addr[sel] = a; wr_dat[sel] = d; wr[sel] = 1'b1;
        @(posedge clk); #1 wr[sel] = 1'b0;
        if (a < NRW) m_rw[a[1:0]] = d;
        @(negedge clk);
        chk({tag, "_pulse"}, W'(wr_pulse[sel]), W'(exp_p));
        chk({tag, "_regs"},  rw_regs[sel], m_pack());
        chk({tag, "_wait"},  W'(wait_rq[sel]), '0);
        @(negedge clk);
        chk({tag, "_pulse_end"}, W'(wr_pulse[sel]), '0);
    endtask

    task automatic do_rd(input logic [A-1:0] a, input logic [D-1:0] exp, input string tag,
                         input logic w = 1'b0, input logic [D-1:0] wd = '0);
        logic [7:0]   vp, wp;
        logic [D-1:0] got;
        vp = '0; wp = '0; got = '0;
        chk({tag, "_idle"}, W'(wait_rq[sel]), '0);
        addr[sel] = a; rd[sel] = 1'b1; wr[sel] = w; wr_dat[sel] = wd;
        @(posedge clk); #1 rd[sel] = 1'b0; wr[sel] = 1'b0;
        if (w && a < NRW) m_rw[a[1:0]] = wd;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            vp[c] = rd_dat_val[sel];
            wp[c] = wait_rq[sel];
            if (rd_dat_val[sel]) got = rd_dat[sel];
        end
        chk({tag, "_valpos"}, W'(vp), W'(1 << lat));
        chk({tag, "_waitpos"}, W'(wp), W'((1 << (lat + 1)) - 2));
        chk({tag, "_dat"}, W'(got), W'(exp));
        chk({tag, "_regs"}, rw_regs[sel], m_pack());
    endtask

    task automatic run_all();
        logic seen;
        do_reset();
        for (int k = 0; k < NRW; k++) do_rd(A'(k), '0, "rd_rst");

        do_wr(8'd2, 64'h1122334455667788, "wr2");
        do_rd(8'd2, 64'h1122334455667788, "rd2");

        do_rd(8'd17, 64'hCAFE, "ro17");
        do_rd(8'd16, 64'h5A5A_0000_1234_0F0F, "ro16");
        do_wr(8'd17, 64'hFFFF, "wr_ro");
        do_rd(8'd17, 64'hCAFE, "ro17_again");

        do_wr(8'd1, 64'hA, "wr1");
        do_rd(8'd1, 64'hA, "rdwr1", 1'b1, 64'hB);
        do_rd(8'd1, 64'hB, "rd1_new");

        // Write held through a read's wait window must not take effect until wait falls.
        addr[sel] = 8'd0; rd[sel] = 1'b1;
        @(posedge clk); #1 rd[sel] = 1'b0;
        addr[sel] = 8'd3; wr_dat[sel] = 64'h33; wr[sel] = 1'b1;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            chk("hold_wait", W'(wait_rq[sel]), W'(1'b1));
            chk("hold_regs", rw_regs[sel], m_pack());
            chk("hold_pulse", W'(wr_pulse[sel]), '0);
        end
        @(negedge clk);
        chk("hold_wait_low", W'(wait_rq[sel]), '0);
        chk("hold_regs_still", rw_regs[sel], m_pack());
        @(posedge clk); #1 wr[sel] = 1'b0;
        m_rw[3] = 64'h33;
        @(negedge clk);
        chk("hold_regs_acc", rw_regs[sel], m_pack());
        chk("hold_pulse_acc", W'(wr_pulse[sel]), W'(4'b1000));
        @(negedge clk);

        do_rd(8'd9, '0, "unmap9");
        do_rd(8'd255, '0, "unmap255");
        do_wr(8'd9, 64'h99, "wr_unmap");

        // Back-to-back writes accepted on consecutive edges.
        addr[sel] = 8'd0; wr_dat[sel] = 64'hD0; wr[sel] = 1'b1;
        @(posedge clk); #1 addr[sel] = 8'd1; wr_dat[sel] = 64'hD1;
        m_rw[0] = 64'hD0;
        @(negedge clk);
        chk("b2b_p0", W'(wr_pulse[sel]), W'(4'b0001));
        chk("b2b_r0", rw_regs[sel], m_pack());
        @(posedge clk); #1 wr[sel] = 1'b0;
        m_rw[1] = 64'hD1;
        @(negedge clk);
        chk("b2b_p1", W'(wr_pulse[sel]), W'(4'b0010));
        chk("b2b_r1", rw_regs[sel], m_pack());
        @(negedge clk);

        do_rd(8'd1, 64'hD1, "rd_pre_rst");

        // Reset lands while a read is in flight.
        addr[sel] = 8'd2; rd[sel] = 1'b1;
        @(posedge clk); #1 rd[sel] = 1'b0;
        @(negedge clk);
        chk("mid_wait", W'(wait_rq[sel]), W'(1'b1));
        rst_n = 1'b0;
        for (int k = 0; k < NRW; k++) m_rw[k] = '0;
        #1;
        chk("mid_rst_regs", rw_regs[sel], '0);
        chk("mid_rst_wait", W'(wait_rq[sel]), '0);
        chk("mid_rst_val",  W'(rd_dat_val[sel]), '0);
        chk("mid_rst_dat",  W'(rd_dat[sel]), '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < lat + 3; c++) begin
            @(negedge clk);
            seen = seen | rd_dat_val[sel];
        end
        chk("mid_rst_noval", W'(seen), '0);
        chk("mid_rst_dat_hold", W'(rd_dat[sel]), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        ro_dat = {64'hCAFE, 64'h5A5A_0000_1234_0F0F};
        for (int s = 0; s < 3; s++) begin
            addr[s] = '0; wr_dat[s] = '0; wr[s] = 1'b0; rd[s] = 1'b0;
        end
        for (int s = 0; s < 3; s++) begin
            sel = s;
            lat = (s == 0) ? 2 : ((s == 1) ? 1 : 5);
            run_all();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
